macro_hub: RTL and testbench
============================

Name: macro_hub

Overview:
- Parametrised replacement for direct multi-macro hookup in the user project wrapper. Today several macros drive the same Wishbone, IO and IRQ nets in parallel; this block gives each macro its own port and ends that contention.
- Decodes Wishbone accesses to one of N_MACRO downstream macro slave ports, with a bus timeout.
- Arbitrates IO pad ownership so only one macro drives io_out/io_oeb, with a guarded switchover.
- Sits directly under user_project_wrapper, between the Caravel Wishbone/IO/IRQ pins and the macros.

Parameters:
- N_MACRO, 4, number of downstream macros (1..15).
- IO_W, 38, IO pad count.
- TIMEOUT, 255, cycles to wait for a macro ack before an error response (1..255).
- GUARD, 4, cycles io_oeb is forced high after an ownership change (1..15).
- BASE, 8'h30, required value of wbs_adr_i[31:24].

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  upstream Wishbone control.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i, wbs_dat_i  in  32 each  upstream address and write data.
- wbs_ack_o  out  1  upstream ack.
- wbs_dat_o  out  32  upstream read data.
- m_cyc_o, m_stb_o  out  N_MACRO each  per-macro cycle/strobe.
- m_we_o  out  1  write enable, broadcast to all macros.
- m_sel_o  out  4  byte selects, broadcast.
- m_adr_o, m_dat_o  out  32 each  address and write data, broadcast.
- m_ack_i  in  N_MACRO  per-macro ack.
- m_dat_i  in  32*N_MACRO  per-macro read data; macro k on bits [32k+31:32k].
- m_io_out_i, m_io_oeb_i  in  IO_W*N_MACRO each  per-macro pad drive and output-enable (flattened, same packing).
- m_irq_i  in  3*N_MACRO  per-macro interrupts.
- io_out, io_oeb  out  IO_W each  pad drive and output-enable.
- user_irq  out  3  combined interrupts.

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, m_cyc_o=0, m_stb_o=0, io_oeb=all 1, io_out=0, user_irq=0, CTRL=0, STATUS=0, FSM=IDLE.
- Address decode is valid only when adr[31:24]==BASE. idx=adr[23:20].
  - idx<N_MACRO: access goes to macro idx.
  - idx==4'hF: access goes to hub registers.
  - Any other idx, or adr[31:24]!=BASE: error access.
- Address and data ports are registered copies of the upstream request, captured on acceptance.
- Hub registers, 32-bit, word offset adr[3:2]:
  - Offset 0, CTRL (R/W):
    - [3:0] io_owner.
    - [4] io_en.
    - [8+N_MACRO-1:8] irq_en.
  - Offset 1, STATUS:
    - [N_MACRO-1:0] sticky timeout flags, write-1-to-clear.
    - [16] last-access-error flag, also write-1-to-clear.
  - Other offsets read 0; writes to them are ignored.
  - Byte selects are ignored; writes are full-word.
- FSM:
  - IDLE: on cyc&stb, latch request and decode.
    - Hub access → HUB; the register write applies in this same cycle.
    - Macro access → WAIT. Assert m_cyc_o[idx] and m_stb_o[idx]; clear the timeout counter.
    - Error access → RESP with data 32'hDEADBEEF; set STATUS[16].
  - HUB: load read data → RESP.
  - WAIT: strobe held until the ack or the abort.
    - m_ack_i[idx]=1: capture m_dat_i slice → RESP; drop strobe the same edge.
    - Counter reaches TIMEOUT with no ack: set STATUS[idx], data=32'hDEADBEEF → RESP; drop strobe.
    - Upstream wbs_cyc_i falls in WAIT: abort → IDLE. Drop strobe; no upstream ack; no flag set.
  - RESP: wbs_ack_o=1 for exactly one cycle, wbs_dat_o valid → IDLE.
- Latency: hub access acks 2 cycles after acceptance; a macro access acks 1 cycle after m_ack_i.
- A new request is not accepted until the FSM is back in IDLE. Back-to-back requests therefore have at least one idle cycle between them.
- Ack and timeout arriving in the same cycle: the ack wins.
- A macro asserting m_ack_i while not addressed is ignored.
- IO ownership:
  - Any CTRL write that changes io_owner or io_en loads the guard counter with GUARD.
  - While guard≠0, io_oeb=all 1 and io_out=0; guard decrements each cycle.
  - When guard==0, io_en==1 and io_owner<N_MACRO: io_out/io_oeb are that owner's slice. Otherwise io_oeb=all 1 and io_out=0.
  - io_out and io_oeb are registered: 1 cycle from the macro pins to the pads.
- user_irq is registered: the bitwise OR of m_irq_i slices k for which irq_en[k]=1.
- Reset asserted mid-transaction: everything returns to reset values immediately; no ack is issued.

Test Plan:
- Write 0x30F00000 with 0x00000312 (owner 2, io_en=1, irq_en=4'b0011) → ack 2 cycles after acceptance.
  - io_oeb all 1 for 4 cycles, then macro 2's pins appear on the pads.
  - Readback returns 0x00000312.
- Read 0x30100008 with macro 1 acking after 3 cycles with 0xCAFEF00D.
  - m_stb_o=4'b0010 for 3 cycles and m_adr_o=0x30100008.
  - wbs_dat_o=0xCAFEF00D with a one-cycle ack.
- Read 0x30000000 with macro 0 never acking → ack after TIMEOUT=255 cycles with data 0xDEADBEEF.
  - STATUS reads 0x1; writing 0x1 to STATUS clears it to 0.
- Access 0x30500000 (idx 5 ≥ N_MACRO) and 0x40000000 → each acks with 0xDEADBEEF; STATUS[16]=1; no m_stb_o asserted.
- Drop wbs_cyc_i in the 2nd WAIT cycle → m_stb_o falls, no wbs_ack_o, no flag set, next request served normally.
- Assert wb_rst_i during WAIT, and with m_irq_i all 1s → all outputs at reset values asynchronously, user_irq=0, io_oeb all 1.

Source files
------------

// File: rtl/macro_hub_if.sv
// Upstream Wishbone slave bus between the Caravel wrapper pins and the macro hub.
interface macro_hub_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/macro_hub.sv
// Macro hub: gives every user macro its own Wishbone, IO and IRQ port.
// Upstream Wishbone accesses are decoded to one macro (with a bus timeout)
// or to the hub's own CTRL/STATUS registers.
// IO pads are owned by a single macro, with a guard period on every ownership change.
// Enabled macro interrupts are ORed onto user_irq.
module macro_hub #(
   parameter int          N_MACRO = 4,
   parameter int          IO_W    = 38,
   parameter int          TIMEOUT = 255,
   parameter int          GUARD   = 4,
   parameter logic [7:0]  BASE    = 8'h30
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   macro_hub_if.slave                wbs,
   output logic [N_MACRO-1:0]        m_cyc_o,
   output logic [N_MACRO-1:0]        m_stb_o,
   output logic                      m_we_o,
   output logic [3:0]                m_sel_o,
   output logic [31:0]               m_adr_o,
   output logic [31:0]               m_dat_o,
   input  logic [N_MACRO-1:0]        m_ack_i,
   input  logic [32*N_MACRO-1:0]     m_dat_i,
   input  logic [IO_W*N_MACRO-1:0]   m_io_out_i,
   input  logic [IO_W*N_MACRO-1:0]   m_io_oeb_i,
   input  logic [3*N_MACRO-1:0]      m_irq_i,
   output logic [IO_W-1:0]           io_out,
   output logic [IO_W-1:0]           io_oeb,
   output logic [2:0]                user_irq
);

   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {IDLE, HUB, WAIT, RESP} state_t;

   state_t              state, state_next;
   logic [3:0]          req_idx;
   logic [7:0]          timer;
   logic [3:0]          io_owner;
   logic                io_en;
   logic [N_MACRO-1:0]  irq_en;
   logic [N_MACRO-1:0]  status_to;
   logic                status_err;
   logic [3:0]          guard;

   logic [3:0]          dec_idx;
   logic                dec_base, dec_hub, dec_macro, accept, hub_wr;
   logic [N_MACRO-1:0]  dec_onehot, req_onehot;
   logic                ack_sel;
   logic [31:0]         dat_sel;
   logic                do_abort, do_ack, do_timeout;
   logic [31:0]         ctrl_word, status_word, hub_rdata;
   logic [IO_W-1:0]     pad_out_sel, pad_oeb_sel;
   logic                own_ok;
   logic [2:0]          irq_or;

   // Decode the upstream request into macro / hub / error targets.
   always_comb begin
      dec_idx   = wbs.wbs_adr_i[23:20];
      dec_base  = (wbs.wbs_adr_i[31:24] == BASE);
      dec_hub   = dec_base && (dec_idx == 4'hF);
      dec_macro = dec_base && (int'(dec_idx) < N_MACRO);
      accept    = (state == IDLE) && wbs.wbs_cyc_i && wbs.wbs_stb_i;
      hub_wr    = accept && dec_hub && wbs.wbs_we_i;
      for (int k = 0; k < N_MACRO; k++) begin
         dec_onehot[k] = (dec_idx == 4'(k));
         req_onehot[k] = (req_idx == 4'(k));
      end
   end

   // Pick ack and read data of the macro currently addressed; others are ignored.
   always_comb begin
      ack_sel = 1'b0;
      dat_sel = '0;
      for (int k = 0; k < N_MACRO; k++) begin
         if (req_onehot[k]) begin
            ack_sel = m_ack_i[k];
            dat_sel = m_dat_i[32*k +: 32];
         end
      end
   end

   // Next-state logic; in WAIT an upstream abort beats everything and an ack beats the timeout.
   always_comb begin
      state_next = state;
      do_abort   = 1'b0;
      do_ack     = 1'b0;
      do_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (dec_hub)        state_next = HUB;
               else if (dec_macro) state_next = WAIT;
               else                state_next = RESP;
            end
         end
         HUB:  state_next = RESP;
         WAIT: begin
            if (!wbs.wbs_cyc_i) begin
               do_abort   = 1'b1;
               state_next = IDLE;
            end else if (ack_sel) begin
               do_ack     = 1'b1;
               state_next = RESP;
            end else if (timer == 8'(TIMEOUT - 1)) begin
               do_timeout = 1'b1;
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_next;
   end

   // Register views of CTRL and STATUS, selected by the latched word offset.
   always_comb begin
      ctrl_word                  = '0;
      ctrl_word[3:0]             = io_owner;
      ctrl_word[4]               = io_en;
      ctrl_word[8 +: N_MACRO]    = irq_en;
      status_word                = '0;
      status_word[N_MACRO-1:0]   = status_to;
      status_word[16]            = status_err;
      case (m_adr_o[3:2])
         2'd0:    hub_rdata = ctrl_word;
         2'd1:    hub_rdata = status_word;
         default: hub_rdata = '0;
      endcase
   end

   // Bus datapath: request capture, macro strobes, timeout counter, upstream response.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wbs.wbs_ack_o <= 1'b0;
         wbs.wbs_dat_o <= '0;
         m_cyc_o       <= '0;
         m_stb_o       <= '0;
         m_we_o        <= 1'b0;
         m_sel_o       <= '0;
         m_adr_o       <= '0;
         m_dat_o       <= '0;
         req_idx       <= '0;
         timer         <= '0;
      end else begin
         wbs.wbs_ack_o <= (state_next == RESP);
         if (accept) begin
            m_we_o  <= wbs.wbs_we_i;
            m_sel_o <= wbs.wbs_sel_i;
            m_adr_o <= wbs.wbs_adr_i;
            m_dat_o <= wbs.wbs_dat_i;
            req_idx <= dec_idx;
            if (dec_macro) begin
               m_cyc_o <= dec_onehot;
               m_stb_o <= dec_onehot;
               timer   <= '0;
            end else if (!dec_hub) begin
               wbs.wbs_dat_o <= ERR_DATA;
            end
         end
         if (state == HUB) wbs.wbs_dat_o <= hub_rdata;
         if (state == WAIT) begin
            if (do_abort || do_ack || do_timeout) begin
               m_cyc_o <= '0;
               m_stb_o <= '0;
            end else begin
               timer <= timer + 8'd1;
            end
            if (do_ack)     wbs.wbs_dat_o <= dat_sel;
            if (do_timeout) wbs.wbs_dat_o <= ERR_DATA;
         end
      end
   end

   // Hub registers: CTRL writes (arming the IO guard), W1C STATUS, sticky timeout/error flags.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         io_owner   <= '0;
         io_en      <= 1'b0;
         irq_en     <= '0;
         status_to  <= '0;
         status_err <= 1'b0;
         guard      <= '0;
      end else begin
         if (guard != 4'd0) guard <= guard - 4'd1;
         if (hub_wr && (wbs.wbs_adr_i[3:2] == 2'd0)) begin
            io_owner <= wbs.wbs_dat_i[3:0];
            io_en    <= wbs.wbs_dat_i[4];
            irq_en   <= wbs.wbs_dat_i[8 +: N_MACRO];
            if ((wbs.wbs_dat_i[3:0] != io_owner) || (wbs.wbs_dat_i[4] != io_en))
               guard <= 4'(GUARD);
         end
         if (hub_wr && (wbs.wbs_adr_i[3:2] == 2'd1)) begin
            status_to  <= status_to & ~wbs.wbs_dat_i[N_MACRO-1:0];
            status_err <= status_err & ~wbs.wbs_dat_i[16];
         end
         if (do_timeout) status_to <= status_to | req_onehot;
         if (accept && !dec_hub && !dec_macro) status_err <= 1'b1;
      end
   end

   // Select the owning macro's pad slice and OR the enabled interrupt slices.
   always_comb begin
      pad_out_sel = '0;
      pad_oeb_sel = '1;
      irq_or      = '0;
      for (int k = 0; k < N_MACRO; k++) begin
         if (io_owner == 4'(k)) begin
            pad_out_sel = m_io_out_i[IO_W*k +: IO_W];
            pad_oeb_sel = m_io_oeb_i[IO_W*k +: IO_W];
         end
         if (irq_en[k]) irq_or = irq_or | m_irq_i[3*k +: 3];
      end
      own_ok = (guard == 4'd0) && io_en && (int'(io_owner) < N_MACRO);
   end

   // Registered pad and interrupt outputs; pads stay released while guarded or unowned.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         io_out   <= '0;
         io_oeb   <= '1;
         user_irq <= '0;
      end else begin
         io_out   <= own_ok ? pad_out_sel : '0;
         io_oeb   <= own_ok ? pad_oeb_sel : '1;
         user_irq <= irq_or;
      end
   end

endmodule

// File: tb/tb_macro_hub.sv
// Directed bench for macro_hub: register access, macro read, timeout,
// decode errors, upstream abort, IO guard/ownership, IRQ merge and async reset.
module tb_macro_hub;

   localparam int N_MACRO = 4;
   localparam int IO_W    = 38;
   localparam int TIMEOUT = 255;
   localparam int GUARD   = 4;

   logic                     clk;
   logic                     rst;
   logic [N_MACRO-1:0]       m_cyc_o, m_stb_o;
   logic                     m_we_o;
   logic [3:0]               m_sel_o;
   logic [31:0]              m_adr_o, m_dat_o;
   logic [N_MACRO-1:0]       m_ack_i;
   logic [32*N_MACRO-1:0]    m_dat_i;
   logic [IO_W*N_MACRO-1:0]  m_io_out_i, m_io_oeb_i;
   logic [3*N_MACRO-1:0]     m_irq_i;
   logic [IO_W-1:0]          io_out, io_oeb;
   logic [2:0]               user_irq;

   int compare_cnt  = 0;
   int mismatch_cnt = 0;

   macro_hub_if wbs_bus ();

   macro_hub #(
      .N_MACRO(N_MACRO), .IO_W(IO_W), .TIMEOUT(TIMEOUT), .GUARD(GUARD), .BASE(8'h30)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs(wbs_bus.slave),
      .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
      .m_io_out_i(m_io_out_i), .m_io_oeb_i(m_io_oeb_i), .m_irq_i(m_irq_i),
      .io_out(io_out), .io_oeb(io_oeb), .user_irq(user_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [IO_W-1:0] pin_out(input int k);
      return IO_W'(64'h2A_5555_0000 + 64'(k));
   endfunction

   function automatic logic [IO_W-1:0] pin_oeb(input int k);
      return IO_W'(64'h15_0F0F_00F0 + 64'(k));
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compare_cnt++;
      assert (obs === exp) else begin
         mismatch_cnt++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents a request at a falling edge; the next rising edge accepts it.
   task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [31:0] dat);
      @(negedge clk);
      wbs_bus.wbs_cyc_i = 1'b1;
      wbs_bus.wbs_stb_i = 1'b1;
      wbs_bus.wbs_we_i  = we;
      wbs_bus.wbs_sel_i = 4'hF;
      wbs_bus.wbs_adr_i = adr;
      wbs_bus.wbs_dat_i = dat;
   endtask

   // Waits for the ack, returns how many cycles it took (0 if never) and the data.
   task automatic wait_ack(input int limit, output int n, output logic [31:0] data);
      n    = 0;
      data = '0;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         if (wbs_bus.wbs_ack_o === 1'b1) begin
            n    = c;
            data = wbs_bus.wbs_dat_o;
            break;
         end
      end
      wbs_bus.wbs_cyc_i = 1'b0;
      wbs_bus.wbs_stb_i = 1'b0;
      wbs_bus.wbs_we_i  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      logic [31:0] d;

      rst = 1'b1;
      wbs_bus.wbs_cyc_i = 1'b0;
      wbs_bus.wbs_stb_i = 1'b0;
      wbs_bus.wbs_we_i  = 1'b0;
      wbs_bus.wbs_sel_i = '0;
      wbs_bus.wbs_adr_i = '0;
      wbs_bus.wbs_dat_i = '0;
      m_ack_i = '0;
      m_dat_i = '0;
      for (int k = 0; k < N_MACRO; k++) begin
         m_io_out_i[IO_W*k +: IO_W] = pin_out(k);
         m_io_oeb_i[IO_W*k +: IO_W] = pin_oeb(k);
      end
      m_irq_i = {3'b100, 3'b100, 3'b010, 3'b001};

      repeat (2) @(negedge clk);
      checkOutput("rst_ack", 64'(wbs_bus.wbs_ack_o), 64'd0);
      checkOutput("rst_dat", 64'(wbs_bus.wbs_dat_o), 64'd0);
      checkOutput("rst_cyc", 64'(m_cyc_o), 64'd0);
      checkOutput("rst_stb", 64'(m_stb_o), 64'd0);
      checkOutput("rst_oeb", 64'(io_oeb), 64'({IO_W{1'b1}}));
      checkOutput("rst_out", 64'(io_out), 64'd0);
      checkOutput("rst_irq", 64'(user_irq), 64'd0);
      rst = 1'b0;

      // CTRL write: owner 2, io_en, irq_en 0011
      applyStimulus(32'h30F0_0000, 1'b1, 32'h0000_0312);
      wait_ack(10, n, d);
      checkOutput("ctrl_wr_latency", 64'(n), 64'd2);
      @(negedge clk);
      checkOutput("guard_oeb_c3", 64'(io_oeb), 64'({IO_W{1'b1}}));
      checkOutput("guard_out_c3", 64'(io_out), 64'd0);
      @(negedge clk);
      checkOutput("guard_oeb_c4", 64'(io_oeb), 64'({IO_W{1'b1}}));
      repeat (2) @(negedge clk);
      checkOutput("owner2_out", 64'(io_out), 64'(pin_out(2)));
      checkOutput("owner2_oeb", 64'(io_oeb), 64'(pin_oeb(2)));
      checkOutput("irq_merge", 64'(user_irq), 64'(3'b011));

      applyStimulus(32'h30F0_0000, 1'b0, 32'h0);
      wait_ack(10, n, d);
      checkOutput("ctrl_rd_latency", 64'(n), 64'd2);
      checkOutput("ctrl_rd_data", 64'(d), 64'h312);

      // Macro 1 read, macro 0 acking while not addressed must be ignored
      applyStimulus(32'h3010_0008, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("m1_stb_c1", 64'(m_stb_o), 64'(4'b0010));
      checkOutput("m1_cyc_c1", 64'(m_cyc_o), 64'(4'b0010));
      checkOutput("m1_adr", 64'(m_adr_o), 64'h3010_0008);
      m_ack_i = 4'b0001;
      @(negedge clk);
      checkOutput("m1_stb_c2", 64'(m_stb_o), 64'(4'b0010));
      checkOutput("m1_noack_c2", 64'(wbs_bus.wbs_ack_o), 64'd0);
      m_ack_i = 4'b0000;
      @(negedge clk);
      checkOutput("m1_stb_c3", 64'(m_stb_o), 64'(4'b0010));
      m_ack_i = 4'b0010;
      m_dat_i[32*1 +: 32] = 32'hCAFE_F00D;
      wait_ack(5, n, d);
      m_ack_i = 4'b0000;
      checkOutput("m1_ack_latency", 64'(n), 64'd1);
      checkOutput("m1_data", 64'(d), 64'hCAFE_F00D);
      checkOutput("m1_stb_dropped", 64'(m_stb_o), 64'd0);
      @(negedge clk);
      checkOutput("m1_ack_one_cycle", 64'(wbs_bus.wbs_ack_o), 64'd0);

      // Macro 0 never acks: timeout after TIMEOUT strobe cycles
      applyStimulus(32'h3000_0000, 1'b0, 32'h0);
      wait_ack(300, n, d);
      checkOutput("to_latency", 64'(n), 64'(TIMEOUT + 1));
      checkOutput("to_data", 64'(d), 64'hDEAD_BEEF);
      applyStimulus(32'h30F0_0004, 1'b0, 32'h0);
      wait_ack(10, n, d);
      checkOutput("status_to_set", 64'(d), 64'h1);
      applyStimulus(32'h30F0_0004, 1'b1, 32'h1);
      wait_ack(10, n, d);
      checkOutput("status_w1c_latency", 64'(n), 64'd2);

      // Ack arriving on the last cycle before timeout wins
      applyStimulus(32'h3030_0000, 1'b0, 32'h0);
      repeat (TIMEOUT) @(negedge clk);
      m_ack_i = 4'b1000;
      m_dat_i[32*3 +: 32] = 32'h1234_5678;
      wait_ack(5, n, d);
      m_ack_i = 4'b0000;
      checkOutput("ackwin_latency", 64'(n), 64'd1);
      checkOutput("ackwin_data", 64'(d), 64'h1234_5678);
      applyStimulus(32'h30F0_0004, 1'b0, 32'h0);
      wait_ack(10, n, d);
      checkOutput("status_cleared", 64'(d), 64'h0);

      // Decode errors: idx beyond N_MACRO, and wrong base
      applyStimulus(32'h3050_0000, 1'b0, 32'h0);
      wait_ack(10, n, d);
      checkOutput("err_idx_latency", 64'(n), 64'd1);
      checkOutput("err_idx_data", 64'(d), 64'hDEAD_BEEF);
      checkOutput("err_idx_nostb", 64'(m_stb_o), 64'd0);
      applyStimulus(32'h4000_0000, 1'b1, 32'hFFFF_FFFF);
      wait_ack(10, n, d);
      checkOutput("err_base_latency", 64'(n), 64'd1);
      checkOutput("err_base_data", 64'(d), 64'hDEAD_BEEF);
      checkOutput("err_base_nostb", 64'(m_stb_o), 64'd0);
      applyStimulus(32'h30F0_0004, 1'b0, 32'h0);
      wait_ack(10, n, d);
      checkOutput("status_err_flag", 64'(d), 64'h0001_0000);

      // Upstream abort in the second WAIT cycle
      applyStimulus(32'h3020_0000, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("abort_stb_c1", 64'(m_stb_o), 64'(4'b0100));
      @(negedge clk);
      wbs_bus.wbs_cyc_i = 1'b0;
      wbs_bus.wbs_stb_i = 1'b0;
      @(negedge clk);
      checkOutput("abort_stb_drop", 64'(m_stb_o), 64'd0);
      checkOutput("abort_cyc_drop", 64'(m_cyc_o), 64'd0);
      checkOutput("abort_noack_a", 64'(wbs_bus.wbs_ack_o), 64'd0);
      @(negedge clk);
      checkOutput("abort_noack_b", 64'(wbs_bus.wbs_ack_o), 64'd0);
      applyStimulus(32'h30F0_0004, 1'b0, 32'h0);
      wait_ack(10, n, d);
      checkOutput("after_abort_latency", 64'(n), 64'd2);
      checkOutput("after_abort_status", 64'(d), 64'h0001_0000);

      // All interrupts high, then reset in the middle of a WAIT
      m_irq_i = '1;
      repeat (2) @(negedge clk);
      checkOutput("irq_all_enabled", 64'(user_irq), 64'(3'b111));
      applyStimulus(32'h3010_0000, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("rstw_stb", 64'(m_stb_o), 64'(4'b0010));
      #2 rst = 1'b1;
      #1;
      checkOutput("rstw_ack", 64'(wbs_bus.wbs_ack_o), 64'd0);
      checkOutput("rstw_dat", 64'(wbs_bus.wbs_dat_o), 64'd0);
      checkOutput("rstw_stb_clr", 64'(m_stb_o), 64'd0);
      checkOutput("rstw_cyc_clr", 64'(m_cyc_o), 64'd0);
      checkOutput("rstw_oeb", 64'(io_oeb), 64'({IO_W{1'b1}}));
      checkOutput("rstw_out", 64'(io_out), 64'd0);
      checkOutput("rstw_irq", 64'(user_irq), 64'd0);
      wbs_bus.wbs_cyc_i = 1'b0;
      wbs_bus.wbs_stb_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("post_rst_noack", 64'(wbs_bus.wbs_ack_o), 64'd0);
      checkOutput("post_rst_irq", 64'(user_irq), 64'd0);
      checkOutput("post_rst_oeb", 64'(io_oeb), 64'({IO_W{1'b1}}));
      applyStimulus(32'h30F0_0000, 1'b0, 32'h0);
      wait_ack(10, n, d);
      checkOutput("post_rst_ctrl", 64'(d), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
      $finish;
   end

endmodule
